// File: rtl/sar_scan_pkg.sv
// Shared types and default constants for the SAR scan controller.
package sar_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SAMPLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    localparam int DEF_CHANNELS   = 4;
    localparam int DEF_WIDTH      = 8;
    localparam int DEF_SAMPLE_CYC = 4;
    localparam int DEF_SETTLE     = 2;

    // Width of an index into n items, never below one bit.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sar_bit_engine.sv
// Successive-approximation trial register: walks MSB to LSB, holding each
// trial code for SETTLE cycles and resolving it from the comparator.
module sar_bit_engine
    import sar_scan_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             step,
    input  logic             comp_in,
    output logic [WIDTH-1:0] code,
    output logic             last
);

    localparam int IW  = sel_width(WIDTH);
    localparam int CNW = sel_width(SETTLE);

    logic [IW-1:0]  idx;
    logic [CNW-1:0] cnt;

    // Only meaningful while stepping; the top gates it with the CONVERT state.
    assign last = (idx == '0) && (cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            code <= '0;
            idx  <= '0;
            cnt  <= '0;
        end else if (clr) begin
            code <= '0;
            idx  <= '0;
            cnt  <= '0;
        end else if (load) begin
            code <= {1'b1, {(WIDTH-1){1'b0}}};
            idx  <= IW'(WIDTH - 1);
            cnt  <= CNW'(SETTLE - 1);
        end else if (step) begin
            if (cnt != '0) begin
                cnt <= cnt - CNW'(1);
            end else begin
                code[idx] <= comp_in;
                if (idx != '0) begin
                    code[idx - IW'(1)] <= 1'b1;
                    idx                <= idx - IW'(1);
                    cnt                <= CNW'(SETTLE - 1);
                end
            end
        end
    end

endmodule

// File: rtl/sar_scan_ctrl.sv
// Multi-channel SAR ADC scan controller: channel sequencing, sample/hold
// timing, conversion control and a one-deep result buffer with overrun flag.
module sar_scan_ctrl
    import sar_scan_pkg::*;
#(
    parameter int CHANNELS   = DEF_CHANNELS,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int SAMPLE_CYC = DEF_SAMPLE_CYC,
    parameter int SETTLE     = DEF_SETTLE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              ena,
    input  logic                              start,
    input  logic                              cont,
    input  logic [CHANNELS-1:0]               ch_mask,
    input  logic                              comp_in,
    output logic [WIDTH-1:0]                  dac_code,
    output logic [sel_width(CHANNELS)-1:0]    mux_sel,
    output logic                              sample_hold,
    output logic                              busy,
    output logic                              res_valid,
    input  logic                              res_ready,
    output logic [sel_width(CHANNELS)-1:0]    res_ch,
    output logic [WIDTH-1:0]                  res_data,
    output logic                              overrun,
    input  logic                              ovr_clr
);

    localparam int CW  = sel_width(CHANNELS);
    localparam int PW  = CW + 1;
    localparam int SCW = sel_width(SAMPLE_CYC);

    state_t          state;
    logic [PW-1:0]   ptr;
    logic [SCW-1:0]  samp_cnt;
    logic            mode_cont;
    logic            hit_any;
    logic [CW-1:0]   hit_ch;
    logic [CW-1:0]   low_ch;
    logic [CW-1:0]   sel_ch;
    logic            go_sel;
    logic            eng_load;
    logic            eng_step;
    logic            eng_last;

    // Descending scan so the final assignment is the lowest matching channel.
    always_comb begin
        hit_any = 1'b0;
        hit_ch  = '0;
        low_ch  = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                low_ch = CW'(i);
                if (i >= int'(ptr)) begin
                    hit_any = 1'b1;
                    hit_ch  = CW'(i);
                end
            end
        end
    end

    assign sel_ch   = hit_any ? hit_ch : low_ch;
    assign go_sel   = hit_any || (mode_cont && cont && (|ch_mask));
    assign eng_load = ena && (state == ST_SAMPLE) && (samp_cnt == '0);
    assign eng_step = ena && (state == ST_CONVERT);

    sar_bit_engine #(
        .WIDTH  (WIDTH),
        .SETTLE (SETTLE)
    ) u_bit_engine (
        .clk     (clk),
        .rst     (rst),
        .clr     (!eng_load && !eng_step),
        .load    (eng_load),
        .step    (eng_step),
        .comp_in (comp_in),
        .code    (dac_code),
        .last    (eng_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            sample_hold <= 1'b0;
            mux_sel     <= '0;
            ptr         <= '0;
            samp_cnt    <= '0;
            mode_cont   <= 1'b0;
        end else if (!ena) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            sample_hold <= 1'b0;
            ptr         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && (|ch_mask)) begin
                        state     <= ST_SELECT;
                        busy      <= 1'b1;
                        mode_cont <= cont;
                        ptr       <= '0;
                    end
                end
                ST_SELECT: begin
                    if (go_sel) begin
                        state       <= ST_SAMPLE;
                        mux_sel     <= sel_ch;
                        ptr         <= PW'(sel_ch) + PW'(1);
                        sample_hold <= 1'b1;
                        samp_cnt    <= SCW'(SAMPLE_CYC - 1);
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end
                end
                ST_SAMPLE: begin
                    if (samp_cnt == '0) begin
                        state       <= ST_CONVERT;
                        sample_hold <= 1'b0;
                    end else begin
                        samp_cnt <= samp_cnt - SCW'(1);
                    end
                end
                ST_CONVERT: begin
                    if (eng_last) state <= ST_DONE;
                end
                ST_DONE: begin
                    // A continuous scan whose cont dropped stops after this result.
                    if (mode_cont && !cont) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        state <= ST_SELECT;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_ch    <= '0;
            res_data  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;
            if (ena && (state == ST_DONE)) begin
                res_valid <= 1'b1;
                res_ch    <= mux_sel;
                res_data  <= dac_code;
            end
            if (ena && (state == ST_DONE) && res_valid && !res_ready) overrun <= 1'b1;
            else if (ovr_clr) overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sar_scan_ctrl.sv
// Directed testbench for sar_scan_ctrl with default parameters; a
// threshold comparator per channel stands in for the analog front end.
module tb_sar_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, ena, start, cont, comp_in, res_ready, ovr_clr;
    logic [3:0] ch_mask;
    logic [7:0] dac_code, res_data;
    logic [1:0] mux_sel, res_ch;
    logic       sample_hold, busy, res_valid, overrun;
    logic [7:0] thr [4];
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         cyc = 0;

    sar_scan_ctrl dut (
        .clk (clk), .rst (rst), .ena (ena), .start (start), .cont (cont),
        .ch_mask (ch_mask), .comp_in (comp_in), .dac_code (dac_code),
        .mux_sel (mux_sel), .sample_hold (sample_hold), .busy (busy),
        .res_valid (res_valid), .res_ready (res_ready), .res_ch (res_ch),
        .res_data (res_data), .overrun (overrun), .ovr_clr (ovr_clr)
    );

    always #5 clk = ~clk;

    // Input voltage of the selected channel is >= the DAC trial code.
    assign comp_in = (dac_code <= thr[mux_sel]);

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 0;
    endtask

    task automatic drain();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; ena = 1'b1; start = 1'b0; cont = 1'b0; ch_mask = 4'b0000;
        res_ready = 1'b0; ovr_clr = 1'b0;
        thr[0] = 8'h00; thr[1] = 8'h00; thr[2] = 8'h00; thr[3] = 8'h00;
        tick(); tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        chk_cnt++; if (dac_code !== 8'h00) $display("FAIL reset_dac: got %h want 00", dac_code); else pass_cnt++;
        chk_cnt++; if ({res_valid, sample_hold, overrun} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {res_valid, sample_hold, overrun}); else pass_cnt++;
        chk_cnt++; if ({mux_sel, res_ch, res_data} !== 12'h000) $display("FAIL reset_sel_res: got %h want 000", {mux_sel, res_ch, res_data}); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic done;
        ch_mask = 4'b0001; cont = 1'b0; res_ready = 1'b0; thr[0] = 8'h5A;
        pulse_start();
        done = 1'b0;
        while (!done && cyc < 60) begin
            tick();
            if (cyc == 1) begin
                chk_cnt++; if (sample_hold !== 1'b1) $display("FAIL single_track: got %b want 1", sample_hold); else pass_cnt++;
            end
            if (cyc == 5) begin
                chk_cnt++; if ({sample_hold, dac_code} !== 9'h080) $display("FAIL single_msb_trial: got %h want 080", {sample_hold, dac_code}); else pass_cnt++;
            end
            if (cyc == 7) begin
                chk_cnt++; if (dac_code !== 8'h40) $display("FAIL single_second_trial: got %h want 40", dac_code); else pass_cnt++;
            end
            if (res_valid) done = 1'b1;
        end
        chk_cnt++; if (cyc !== 22) $display("FAIL single_latency: got %0d want 22", cyc); else pass_cnt++;
        chk_cnt++; if ({res_ch, res_data} !== 10'h05A) $display("FAIL single_result: got ch %0d data %h want ch 0 data 5a", res_ch, res_data); else pass_cnt++;
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL single_idle_after: got %b want 0", busy); else pass_cnt++;
        repeat (3) tick();
        chk_cnt++; if ({res_valid, res_data} !== 9'h15A) $display("FAIL single_hold: got %h want 15a", {res_valid, res_data}); else pass_cnt++;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_cnt++; if (res_valid !== 1'b0) $display("FAIL single_consume: got %b want 0", res_valid); else pass_cnt++;
    endtask

    task automatic test_mask_1010();
        logic [1:0] chs [4];
        logic [7:0] dats [4];
        int n;
        thr[0] = 8'h11; thr[1] = 8'h22; thr[2] = 8'h33; thr[3] = 8'h44;
        ch_mask = 4'b1010; cont = 1'b0; res_ready = 1'b1;
        n = 0;
        pulse_start();
        while (busy && cyc < 150) begin
            tick();
            if (res_valid) begin
                if (n < 4) begin
                    chs[n] = res_ch;
                    dats[n] = res_data;
                end
                n++;
            end
        end
        chk_cnt++; if (n !== 2) $display("FAIL mask1010_count: got %0d results want 2", n); else pass_cnt++;
        if (n >= 2) begin
            chk_cnt++; if ({chs[0], dats[0]} !== 10'h122) $display("FAIL mask1010_first: got ch %0d data %h want ch 1 data 22", chs[0], dats[0]); else pass_cnt++;
            chk_cnt++; if ({chs[1], dats[1]} !== 10'h344) $display("FAIL mask1010_second: got ch %0d data %h want ch 3 data 44", chs[1], dats[1]); else pass_cnt++;
        end
        res_ready = 1'b0;
        tick();
    endtask

    task automatic test_cont_overrun();
        thr[0] = 8'h3C; thr[3] = 8'hC3;
        ch_mask = 4'b1001; cont = 1'b1; res_ready = 1'b0;
        pulse_start();
        while (!res_valid && cyc < 40) tick();
        chk_cnt++; if ({res_valid, res_ch, overrun} !== 4'b1000) $display("FAIL cont_first: got valid %b ch %0d ovr %b want 1 0 0", res_valid, res_ch, overrun); else pass_cnt++;
        while (!overrun && cyc < 80) tick();
        chk_cnt++; if (cyc !== 44) $display("FAIL cont_overrun_time: got %0d want 44", cyc); else pass_cnt++;
        chk_cnt++; if ({res_valid, res_ch, res_data} !== 11'h7C3) $display("FAIL cont_overwrite: got valid %b ch %0d data %h want 1 3 c3", res_valid, res_ch, res_data); else pass_cnt++;
        ovr_clr = 1'b1;
        tick();
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL cont_ovr_clr: got %b want 0", overrun); else pass_cnt++;
        while (res_ch !== 2'd0 && cyc < 100) tick();
        chk_cnt++; if ({overrun, res_data} !== 9'h13C) $display("FAIL cont_set_beats_clr: got ovr %b data %h want 1 3c", overrun, res_data); else pass_cnt++;
        ovr_clr = 1'b0;
        cont = 1'b0;
        while (busy && cyc < 160) tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL cont_stop: got busy %b want 0", busy); else pass_cnt++;
        drain();
    endtask

    task automatic test_back_to_back();
        ch_mask = 4'b1001; cont = 1'b1; res_ready = 1'b0;
        pulse_start();
        while (cyc < 43) tick();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk_cnt++; if ({res_valid, res_ch, res_data} !== 11'h7C3) $display("FAIL b2b_new_result: got valid %b ch %0d data %h want 1 3 c3", res_valid, res_ch, res_data); else pass_cnt++;
        chk_cnt++; if (overrun !== 1'b0) $display("FAIL b2b_no_overrun: got %b want 0", overrun); else pass_cnt++;
        cont = 1'b0;
        while (busy && cyc < 120) tick();
        drain();
    endtask

    task automatic test_abort();
        logic seen;
        ch_mask = 4'b0001; cont = 1'b0; res_ready = 1'b0; thr[0] = 8'hA5;
        pulse_start();
        while (cyc < 10) tick();
        chk_cnt++; if (busy !== 1'b1) $display("FAIL abort_busy_before: got %b want 1", busy); else pass_cnt++;
        ena = 1'b0;
        tick();
        chk_cnt++; if ({busy, sample_hold, dac_code} !== 10'h000) $display("FAIL abort_idle: got busy %b sh %b dac %h want 0 0 00", busy, sample_hold, dac_code); else pass_cnt++;
        ena = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (res_valid || busy) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL abort_no_result: got activity %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_mask_zero();
        logic seen;
        ch_mask = 4'b0000; cont = 1'b0; res_ready = 1'b0;
        seen = 1'b0;
        pulse_start();
        if (busy) seen = 1'b1;
        repeat (5) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL mask0_busy: got %b want 0", seen); else pass_cnt++;
        ch_mask = 4'b0001; thr[0] = 8'h5A;
        pulse_start();
        while (cyc < 7) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        while (!res_valid && cyc < 60) tick();
        chk_cnt++; if (cyc !== 22) $display("FAIL restart_ignored: got latency %0d want 22", cyc); else pass_cnt++;
        tick();
        drain();
        cont = 1'b1;
        pulse_start();
        while (cyc < 3) tick();
        ch_mask = 4'b0000;
        while (!res_valid && cyc < 60) tick();
        chk_cnt++; if ({res_valid, res_data} !== 9'h15A) $display("FAIL mask_drop_result: got %h want 15a", {res_valid, res_data}); else pass_cnt++;
        tick();
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mask_drop_idle: got busy %b want 0", busy); else pass_cnt++;
        cont = 1'b0;
        drain();
    endtask

    task automatic test_reset_mid();
        logic seen;
        ch_mask = 4'b1110; cont = 1'b1; res_ready = 1'b1;
        pulse_start();
        while (cyc < 12) tick();
        rst = 1'b1;
        #1;
        chk_cnt++; if ({busy, sample_hold, dac_code} !== 10'h000) $display("FAIL rst_async_ctrl: got busy %b sh %b dac %h want 0 0 00", busy, sample_hold, dac_code); else pass_cnt++;
        chk_cnt++; if ({mux_sel, res_valid, res_ch, res_data, overrun} !== 14'h0000) $display("FAIL rst_async_result: got %h want 0000", {mux_sel, res_valid, res_ch, res_data, overrun}); else pass_cnt++;
        tick();
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (busy || res_valid || sample_hold) seen = 1'b1;
        end
        chk_cnt++; if (seen !== 1'b0) $display("FAIL rst_no_activity: got %b want 0", seen); else pass_cnt++;
        cont = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_mask_1010();
        test_cont_overrun();
        test_back_to_back();
        test_abort();
        test_mask_zero();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/sar_scan_ctrl.md
SAR_SCAN_CTRL -- requirements
Module: sar_scan_ctrl

Interface
REQ-001 Parameter CHANNELS, default 4, analog input channels scanned (1..8).
REQ-002 Parameter WIDTH, default 8, conversion resolution in bits (2..12).
REQ-003 Parameter SAMPLE_CYC, default 4, sample/hold cycles per conversion (>=1).
REQ-004 Parameter SETTLE, default 2, clock cycles per SAR bit trial (>=1).
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 ena  in  1  block enable; low aborts activity.
REQ-008 start  in  1  one-cycle pulse begins a scan.
REQ-009 cont  in  1  continuous-scan mode select.
REQ-010 ch_mask  in  CHANNELS  per-channel enable.
REQ-011 comp_in  in  1  comparator output, synchronous to clk; 1 = input >= DAC.
REQ-012 dac_code  out  WIDTH  trial code to external DAC.
REQ-013 mux_sel  out  max(1,clog2(CHANNELS))  analog mux channel select.
REQ-014 sample_hold  out  1  high = track, low = hold.
REQ-015 busy  out  1  high whenever not IDLE.
REQ-016 res_valid / res_ready  out/in  1  result handshake; transfer when both high.
REQ-017 res_ch / res_data  out  mux_sel width / WIDTH  channel and code of held result.
REQ-018 overrun  out  1  sticky lost-result flag; ovr_clr (in, 1) clears it.

Function
REQ-019 FSM states IDLE, SELECT, SAMPLE, CONVERT, DONE.
REQ-020 IDLE->SELECT on start=1, ena=1, ch_mask!=0; start otherwise ignored, including while busy.
REQ-021 SELECT (1 cycle): choose lowest enabled channel >= scan pointer, load mux_sel; ch_mask sampled here only.
REQ-022 SAMPLE: sample_hold=1 for exactly SAMPLE_CYC cycles, dac_code=0.
REQ-023 CONVERT: bits MSB->LSB; each trial sets bit, holds dac_code SETTLE cycles, samples comp_in on last cycle; bit kept if comp_in=1 else cleared.
REQ-024 DONE (1 cycle): final code loaded into result buffer; res_valid high next cycle.
REQ-025 Latency start-pulse cycle to res_valid rise = 1 + SAMPLE_CYC + WIDTH*SETTLE + 1 cycles (default: 22).
REQ-026 Single scan (cont=0): each channel enabled at its SELECT converted once ascending, then IDLE.
REQ-027 Continuous (cont=1): after highest enabled channel, wrap to lowest enabled; repeat without start.
REQ-028 cont deasserted mid-conversion: current conversion completes, then IDLE.
REQ-029 ch_mask becomes 0 during scan: next SELECT goes to IDLE with no further conversion.
REQ-030 Result buffer one-deep; res_valid held with res_ch/res_data stable until res_ready.
REQ-031 New result at DONE while res_valid=1 and res_ready=0: overwrite buffer, set overrun.
REQ-032 DONE coincident with transfer of old result: no overrun; new result valid next cycle.
REQ-033 ovr_clr and overrun-set same cycle: overrun stays 1.
REQ-034 ena=0 in any state: next cycle IDLE, dac_code=0, sample_hold=0, no result written, buffer kept.

Reset
REQ-035 rst=1: state IDLE, dac_code=0, mux_sel=0, sample_hold=0, busy=0, res_valid=0, res_ch=0, res_data=0, overrun=0, scan pointer=0.
REQ-036 Reset mid-conversion discards partial code; no res_valid pulse after release.

Structure
REQ-037 Package sar_scan_pkg holds FSM state enum and parameter default constants.
REQ-038 Sub-module sar_bit_engine holds trial register, bit index and settle counter; FSM, channel select and result buffer in top.

Verification
REQ-039 Defaults, ch_mask=0001, comp_in=1 when dac_code<=0x5A: start -> res_valid at cycle 22, res_data=0x5A, res_ch=0, busy low afterwards.
REQ-040 ch_mask=1010, cont=0, res_ready=1: results ch1 then ch3, then IDLE; no ch0/ch2.
REQ-041 cont=1, ch_mask=1001, res_ready=0: second result sets overrun, res_data = second code; ovr_clr clears it.
REQ-042 ena=0 at cycle 10 of a conversion: IDLE next cycle, dac_code=0, no res_valid.
REQ-043 ch_mask=0000 with start pulse: busy stays 0; start while busy does not restart conversion.
REQ-044 rst mid-CONVERT then release with cont=1: all outputs at reset values, no activity until start.
